boot_loader: RTL and testbench

Boot copy sequencer between `bootrom` and main RAM. After reset it reads NWORDS 16-bit words from the boot ROM and writes each into RAM starting at RAM_BASE. It holds the CPU in reset while copying, then releases it and reports completion and a 16-bit checksum. If RAM stops acknowledging writes it stops and flags an error.

---
 rtl/boot_loader_if.sv | 36 +++
 rtl/boot_loader.sv | 112 +++++++++++
 tb/tb_boot_loader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_if.sv
// Boot copy bus bundle: ROM read port, RAM write port and CPU/status lines.
// No storage; pure signal grouping.
// master = boot_loader side, slave = memory/system side.
interface boot_loader_if #(
  parameter int RAM_AW = 12
);
  logic              rom_cs;
  logic              rom_we;
  logic [3:0]        rom_addr;
  logic [15:0]       rom_dout;
  logic              ram_cs;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic              ram_ack;
  logic              cpu_hold;
  logic              boot_done;
  logic              boot_err;
  logic [15:0]       checksum;

  modport master (
    output rom_cs, rom_we, rom_addr,
    input  rom_dout,
    output ram_cs, ram_we, ram_addr, ram_din,
    input  ram_ack,
    output cpu_hold, boot_done, boot_err, checksum
  );

  modport slave (
    input  rom_cs, rom_we, rom_addr,
    output rom_dout,
    input  ram_cs, ram_we, ram_addr, ram_din,
    output ram_ack,
    input  cpu_hold, boot_done, boot_err, checksum
  );
endinterface

// File: rtl/boot_loader.sv
// Boot copy sequencer: copies NWORDS ROM words into RAM, then releases the CPU.
// Latency: 2 cycles per word plus one IDLE cycle; each cycle of ram_ack low adds one.
// Backpressure: stalls in WR while ram_ack is low; TIMEOUT consecutive low edges -> sticky error.
module boot_loader #(
  parameter int NWORDS   = 16,
  parameter int RAM_AW   = 12,
  parameter int RAM_BASE = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic          romclk,
  input  logic          rst,
  boot_loader_if.master bl
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0]    C_WC_LAST  = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0]    C_WC_ONE   = WCW'(1);
  localparam logic [3:0]        C_IDX_LAST = 4'(NWORDS - 1);
  localparam logic [RAM_AW-1:0] C_BASE     = RAM_AW'(RAM_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_idx;
  logic [15:0]    r_data;
  logic [WCW-1:0] r_waitcnt;
  logic [15:0]    r_checksum;

  logic w_rom_cs;
  logic w_ram_cs;
  logic w_last;
  logic w_expired;

  assign w_last    = (r_idx == C_IDX_LAST);
  assign w_expired = (r_waitcnt == C_WC_LAST);

  // State register; reset restarts the copy from word 0.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and select outputs; DONE/ERR are terminal.
  always_comb begin
    w_state_nxt = r_state;
    w_rom_cs    = 1'b0;
    w_ram_cs    = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_RD;
      S_RD: begin
        w_rom_cs    = 1'b1;
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_ram_cs = 1'b1;
        if (bl.ram_ack)     w_state_nxt = w_last ? S_DONE : S_RD;
        else if (w_expired) w_state_nxt = S_ERR;
        else                w_state_nxt = S_WR;
      end
      S_DONE:  w_state_nxt = S_DONE;
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Word index, data latch, stall counter and running checksum.
  always_ff @(posedge romclk or posedge rst) begin
    if (rst) begin
      r_idx      <= 4'd0;
      r_data     <= 16'h0000;
      r_waitcnt  <= '0;
      r_checksum <= 16'h0000;
    end else begin
      case (r_state)
        S_RD: begin
          r_data    <= bl.rom_dout;
          r_waitcnt <= '0;
        end
        S_WR: begin
          if (bl.ram_ack) begin
            r_checksum <= r_checksum + r_data;
            if (!w_last) r_idx <= r_idx + 4'd1;
          end else if (!w_expired) begin
            r_waitcnt <= r_waitcnt + C_WC_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come only from registers or state decode, never from ram_ack/rom_dout.
  assign bl.rom_cs    = w_rom_cs;
  assign bl.rom_we    = 1'b0;
  assign bl.rom_addr  = r_idx;
  assign bl.ram_cs    = w_ram_cs;
  assign bl.ram_we    = w_ram_cs;
  assign bl.ram_addr  = C_BASE + RAM_AW'(r_idx);
  assign bl.ram_din   = r_data;
  assign bl.cpu_hold  = (r_state != S_DONE);
  assign bl.boot_done = (r_state == S_DONE);
  assign bl.boot_err  = (r_state == S_ERR);
  assign bl.checksum  = r_checksum;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: two instances (base 0 and base 0xFF8) share ROM image,
// reset and ram_ack; RAM models capture acknowledged writes; edges counted from reset release.
module tb_boot_loader;

  logic romclk = 1'b0;
  logic rst    = 1'b1;
  always #5 romclk = ~romclk;

  boot_loader_if #(.RAM_AW(12)) ifc0 ();
  boot_loader_if #(.RAM_AW(12)) ifc1 ();

  boot_loader #(.NWORDS(16), .RAM_AW(12), .RAM_BASE(0), .TIMEOUT(15)) dut0 (
    .romclk(romclk), .rst(rst), .bl(ifc0.master)
  );
  boot_loader #(.NWORDS(16), .RAM_AW(12), .RAM_BASE(12'hFF8), .TIMEOUT(15)) dut1 (
    .romclk(romclk), .rst(rst), .bl(ifc1.master)
  );

  logic [15:0] rom [16];
  logic [15:0] mem0 [4096];
  logic [15:0] mem1 [4096];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int wr_cnt0;
  int both_cs;
  int lo_from = 1000000;
  int lo_to   = 0;
  logic r_ack;

  // ram_ack is low for edges lo_from+1 .. lo_to
  assign r_ack         = !((cyc >= lo_from) && (cyc < lo_to));
  assign ifc0.ram_ack  = r_ack;
  assign ifc1.ram_ack  = r_ack;
  assign ifc0.rom_dout = ifc0.rom_cs ? rom[ifc0.rom_addr] : 16'hDEAD;
  assign ifc1.rom_dout = ifc1.rom_cs ? rom[ifc1.rom_addr] : 16'hDEAD;

  // Edge counter (value n after edge n), RAM models and protocol monitors.
  always @(posedge romclk or posedge rst) begin
    if (rst) begin
      cyc     <= 0;
      wr_cnt0 <= 0;
      both_cs <= 0;
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= 16'h0000;
        mem1[i] <= 16'h0000;
      end
    end else begin
      cyc <= cyc + 1;
      if (ifc0.ram_cs && ifc0.ram_we && r_ack) begin
        mem0[ifc0.ram_addr] <= ifc0.ram_din;
        wr_cnt0 <= wr_cnt0 + 1;
      end
      if (ifc1.ram_cs && ifc1.ram_we && r_ack) mem1[ifc1.ram_addr] <= ifc1.ram_din;
      if ((ifc0.rom_cs && ifc0.ram_cs) || (ifc1.rom_cs && ifc1.ram_cs)) both_cs <= both_cs + 1;
    end
  end

  task automatic load_image1();
    logic [15:0] img [8];
    img = '{16'hF200, 16'h4000, 16'hF800, 16'h1007, 16'hF400, 16'h3010, 16'h4000, 16'h0007};
    for (int k = 0; k < 16; k++) rom[k] = (k < 8) ? img[k] : 16'h0000;
  endtask

  function automatic logic [15:0] model_sum(input int n);
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < n; k++) s = s + rom[k];
    return s;
  endfunction

  task automatic start_run();
    rst = 1'b1;
    repeat (3) @(negedge romclk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for boot_done or boot_err of dut0; e = edge of first sighting, -1 on timeout.
  task automatic wait_flag(input bit want_err, output int e, output logic hold_before);
    e = -1;
    hold_before = 1'bx;
    for (int i = 0; i < 300; i++) begin
      @(negedge romclk);
      if ((want_err ? ifc0.boot_err : ifc0.boot_done) === 1'b1) begin
        e = cyc;
        return;
      end
      hold_before = ifc0.cpu_hold;
    end
  endtask

  task automatic check_mem0(input string tag);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (mem0[k] !== rom[k]) begin
        n_bad++;
        $display("FAIL %s_mem[%0d]: got %h want %h", tag, k, mem0[k], rom[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge romclk);
    n_cmp++;
    if ({ifc0.rom_cs, ifc0.rom_we, ifc0.ram_cs, ifc0.ram_we, ifc0.cpu_hold, ifc0.boot_done, ifc0.boot_err} !== 7'b0000100) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000100",
               {ifc0.rom_cs, ifc0.rom_we, ifc0.ram_cs, ifc0.ram_we, ifc0.cpu_hold, ifc0.boot_done, ifc0.boot_err});
    end
    n_cmp++;
    if ({ifc0.rom_addr, ifc0.ram_addr, ifc0.ram_din, ifc0.checksum} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {ifc0.rom_addr, ifc0.ram_addr, ifc0.ram_din, ifc0.checksum});
    end
    n_cmp++;
    if (ifc1.ram_addr !== 12'hFF8) begin
      n_bad++;
      $display("FAIL reset_base: got %h want ff8", ifc1.ram_addr);
    end
  endtask

  task automatic test_copy();
    int e;
    logic hb;
    load_image1();
    lo_from = 1000000;
    start_run();
    wait_flag(1'b0, e, hb);
    n_cmp++;
    if (e !== 33) begin n_bad++; $display("FAIL copy_done_edge: got %0d want 33", e); end
    n_cmp++;
    if (hb !== 1'b1 || ifc0.cpu_hold !== 1'b0) begin
      n_bad++;
      $display("FAIL copy_hold_edge: got before=%b at=%b want 1 0", hb, ifc0.cpu_hold);
    end
    check_mem0("copy");
    n_cmp++;
    if (ifc0.checksum !== model_sum(16)) begin
      n_bad++;
      $display("FAIL copy_checksum: got %h want %h", ifc0.checksum, model_sum(16));
    end
    n_cmp++;
    if (wr_cnt0 !== 16) begin n_bad++; $display("FAIL copy_wr_count: got %0d want 16", wr_cnt0); end
    repeat (5) @(negedge romclk);
    n_cmp++;
    if ({ifc0.boot_done, ifc0.boot_err, ifc0.rom_cs, ifc0.ram_cs, ifc0.cpu_hold} !== 5'b10000) begin
      n_bad++;
      $display("FAIL copy_sticky: got %b want 10000",
               {ifc0.boot_done, ifc0.boot_err, ifc0.rom_cs, ifc0.ram_cs, ifc0.cpu_hold});
    end
    n_cmp++;
    if (both_cs !== 0) begin n_bad++; $display("FAIL copy_cs_overlap: got %0d want 0", both_cs); end
  endtask

  task automatic test_wrap();
    int e;
    logic hb;
    logic [11:0] a;
    load_image1();
    lo_from = 1000000;
    start_run();
    wait_flag(1'b0, e, hb);
    n_cmp++;
    if (ifc1.boot_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done: got %b want 1", ifc1.boot_done); end
    for (int k = 0; k < 16; k++) begin
      a = 12'hFF8 + 12'(k);
      n_cmp++;
      if (mem1[a] !== rom[k]) begin
        n_bad++;
        $display("FAIL wrap_mem[%h]: got %h want %h", a, mem1[a], rom[k]);
      end
    end
    n_cmp++;
    if (mem1[12'hFF7] !== 16'h0 || mem1[12'h008] !== 16'h0) begin
      n_bad++;
      $display("FAIL wrap_outside: got %h %h want 0 0", mem1[12'hFF7], mem1[12'h008]);
    end
  endtask

  task automatic test_stall();
    int e;
    logic hb;
    load_image1();
    lo_from = 12;
    lo_to   = 15;
    start_run();
    wait_flag(1'b0, e, hb);
    n_cmp++;
    if (e !== 36) begin n_bad++; $display("FAIL stall_done_edge: got %0d want 36", e); end
    check_mem0("stall");
    n_cmp++;
    if (ifc0.checksum !== model_sum(16)) begin
      n_bad++;
      $display("FAIL stall_checksum: got %h want %h", ifc0.checksum, model_sum(16));
    end
    lo_from = 1000000;
  endtask

  task automatic test_timeout();
    int e;
    logic hb;
    int sel;
    load_image1();
    lo_from = 6;
    lo_to   = 1000000;
    start_run();
    wait_flag(1'b1, e, hb);
    n_cmp++;
    if (e !== 21) begin n_bad++; $display("FAIL timeout_edge: got %0d want 21", e); end
    n_cmp++;
    if ({ifc0.cpu_hold, ifc0.boot_done} !== 2'b10) begin
      n_bad++;
      $display("FAIL timeout_flags: got %b want 10", {ifc0.cpu_hold, ifc0.boot_done});
    end
    n_cmp++;
    if (ifc0.checksum !== 16'h3200) begin
      n_bad++;
      $display("FAIL timeout_checksum: got %h want 3200", ifc0.checksum);
    end
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge romclk);
      if (ifc0.rom_cs || ifc0.ram_cs || ifc0.ram_we) sel++;
    end
    n_cmp++;
    if (sel !== 0 || ifc0.boot_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_terminal: got sel=%0d err=%b want 0 1", sel, ifc0.boot_err);
    end
    lo_from = 1000000;
  endtask

  task automatic test_reset_mid();
    int e;
    logic hb;
    load_image1();
    lo_from = 1000000;
    start_run();
    for (int i = 0; i < 100 && cyc < 20; i++) @(negedge romclk);
    n_cmp++;
    if (ifc0.ram_cs !== 1'b1 || ifc0.ram_addr !== 12'd9) begin
      n_bad++;
      $display("FAIL midrst_pre: got cs=%b addr=%h want 1 009", ifc0.ram_cs, ifc0.ram_addr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ifc0.rom_cs, ifc0.ram_cs, ifc0.ram_we, ifc0.cpu_hold, ifc0.boot_done, ifc0.boot_err} !== 6'b000100) begin
      n_bad++;
      $display("FAIL midrst_ctrl: got %b want 000100",
               {ifc0.rom_cs, ifc0.ram_cs, ifc0.ram_we, ifc0.cpu_hold, ifc0.boot_done, ifc0.boot_err});
    end
    n_cmp++;
    if ({ifc0.rom_addr, ifc0.ram_addr, ifc0.ram_din, ifc0.checksum} !== 48'h0) begin
      n_bad++;
      $display("FAIL midrst_data: got %h want 0", {ifc0.rom_addr, ifc0.ram_addr, ifc0.ram_din, ifc0.checksum});
    end
    @(negedge romclk);
    rst = 1'b0;
    wait_flag(1'b0, e, hb);
    n_cmp++;
    if (e !== 33) begin n_bad++; $display("FAIL midrst_done_edge: got %0d want 33", e); end
    check_mem0("midrst");
  endtask

  task automatic test_all_ones();
    int e;
    logic hb;
    for (int k = 0; k < 16; k++) rom[k] = 16'hFFFF;
    lo_from = 1000000;
    start_run();
    wait_flag(1'b0, e, hb);
    n_cmp++;
    if (ifc0.boot_done !== 1'b1 || ifc0.checksum !== 16'hFFF0) begin
      n_bad++;
      $display("FAIL ones_checksum: got done=%b sum=%h want 1 fff0", ifc0.boot_done, ifc0.checksum);
    end
  endtask

  initial begin
    load_image1();
    test_reset();
    test_copy();
    test_wrap();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_all_ones();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
